mtx_seq_ctrl: RTL
=================

# mtx_seq_ctrl

Parametrised multi-channel transmit sequencer for the multi-tone TX path. It sits between the tone generator and the radio/GPIO front end. For each frame it:
- drives a three-phase synchronisation preamble, with GPIO sync/TX strobes and a muted interval;
- releases the generator for a payload interval of configurable length;
- repeats in continuous mode, or stops in one-shot mode.

Channel count, sample width, preamble phase length and GPIO bit masks are all parameters.

## Interface
Parameters:
- DATA_WIDTH, 16, sample width per I or Q lane
- NCHAN, 2, number of parallel TX channels
- CNT_WIDTH, 24, width of the phase/payload counters
- SYNC_LEN, 8256, cycles per preamble phase (≥2)
- PAYLOAD_LEN, 0, cycles in RUN; 0 = run until enable drops
- GPIO_REG_WIDTH, 12, GPIO bus width
- SYNC_OUT_MASK, 12'h001, GPIO bits driven by sync strobe
- TX_OUT_MASK, 12'h010, GPIO bits driven by TX-active strobe
- TRIG_IN_MASK, 12'h040, GPIO input bits used as external trigger

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  level; start/keep sequencing
- mode  in  1  0 = one-shot, 1 = continuous
- chan_en  in  NCHAN  per-channel output enable
- gen_ready  in  1  generator symbol-boundary/ready pulse
- gen_i, gen_q  in  NCHAN*DATA_WIDTH  generator samples, channel 0 in LSBs
- gen_srst  out  1  generator synchronous reset/hold
- itx, qtx  out  NCHAN*DATA_WIDTH  registered TX samples
- tx_valid  out  1  TX samples valid
- gpio_in  in  GPIO_REG_WIDTH  raw GPIO inputs
- gpio_out  out  GPIO_REG_WIDTH  GPIO output pattern
- busy  out  1  state ≠ IDLE
- state  out  3  current state code
- frame_cnt  out  16  completed RUN intervals, wraps

## Operation
State encoding: IDLE=0, ARM=1, S0=2, S1=3, S2=4, RUN=5.

Transitions:
- IDLE → ARM when enable=1.
- ARM → S0 when gen_ready=1 (and trigger, see Configuration).
- S0 → S1, S1 → S2 and S2 → RUN after exactly SYNC_LEN cycles each.
- RUN ends after PAYLOAD_LEN cycles. At the end, mode=1 → ARM; mode=0 → IDLE.
- With PAYLOAD_LEN=0, RUN never self-terminates.

Per-state outputs:
- IDLE/ARM: gen_srst=1, tx_valid=0, samples 0, gpio_out=0.
- S0: gen_srst=1, tx_valid=1, samples pass, gpio_out=TX_OUT_MASK.
- S1: gen_srst=1, tx_valid=1, samples pass, gpio_out=SYNC_OUT_MASK|TX_OUT_MASK.
- S2: gen_srst=1, tx_valid=0, samples 0, gpio_out=SYNC_OUT_MASK.
- RUN: gen_srst=0, tx_valid=1, samples pass, gpio_out=TX_OUT_MASK.

Channel, counter and control rules:
- "Pass" means lane k equals gen_i/gen_q lane k when chan_en[k]=1; otherwise 0.
- The phase counter loads 1 on entry to each state and advances to SYNC_LEN. The transition fires in the cycle where count==SYNC_LEN (or PAYLOAD_LEN).
- frame_cnt increments by 1 on every RUN exit, including abort.
- enable=0 in any non-IDLE state forces IDLE on the next edge. An abort from RUN counts as a frame.
- gen_ready is ignored outside ARM.
- mode and chan_en are sampled every cycle, with no latching.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, gen_srst=1, itx=qtx=0, tx_valid=0, gpio_out=0, busy=0, frame_cnt=0.
- gen_ready sampled high in ARM → state=S0 on the next edge.
- Sample path: 1-cycle latency from gen_i/gen_q to itx/qtx.
- Outputs reflect the new state in the same cycle that state changes.
- gen_srst falls on the first RUN cycle.
- reset dominates enable and all other events.
- Counters never overflow: requires SYNC_LEN, PAYLOAD_LEN < 2^CNT_WIDTH.

## Configuration
- MTX_SEQ_EXT_TRIG_EN defined:
  - gpio_in & TRIG_IN_MASK is reduced with OR and passed through a 2-flop synchroniser.
  - ARM → S0 requires gen_ready=1 AND a synchronised rising edge, either in the same cycle or latched earlier while in ARM.
  - The latch clears on leaving ARM.
- MTX_SEQ_EXT_TRIG_EN not defined: gpio_in is ignored, and ARM → S0 is gated by gen_ready only.

## Test plan
- Reset, then enable=1, mode=0, SYNC_LEN=4, PAYLOAD_LEN=6, gen_ready pulse → expected response:
  - S0/S1/S2 each last exactly 4 cycles and RUN lasts 6;
  - gpio_out sequence is 0x010, 0x011, 0x001, 0x010, then 0;
  - frame_cnt=1; state returns to IDLE.
- mode=1, same setup, gen_ready every 30 cycles → repeated frames, each starting 1 cycle after the gen_ready sampled in ARM; frame_cnt increments per frame.
- NCHAN=2, chan_en=2'b01, gen_i=ramp → itx lane0 = ramp delayed 1 cycle; lane1=0; both lanes 0 during S2.
- enable dropped mid-S1 → IDLE next cycle; gen_srst=1, outputs 0, frame_cnt unchanged. Dropped mid-RUN → frame_cnt+1.
- gen_ready pulsed during S0/RUN → no effect on counters or state.
- With MTX_SEQ_EXT_TRIG_EN: gen_ready without trigger → stays in ARM; trigger edge followed by gen_ready 10 cycles later → S0 next edge.

Source files
------------

// File: rtl/mtx_seq_ctrl.sv
// Multi-channel TX sequencer: three-phase sync preamble, payload RUN interval, one-shot/continuous.
// Optional external GPIO trigger gating ARM -> S0 when MTX_SEQ_EXT_TRIG_EN is defined.
module mtx_seq_ctrl #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned NCHAN          = 2,
  parameter int unsigned CNT_WIDTH      = 24,
  parameter int unsigned SYNC_LEN       = 8256,
  parameter int unsigned PAYLOAD_LEN    = 0,
  parameter int unsigned GPIO_REG_WIDTH = 12,
  parameter logic [GPIO_REG_WIDTH-1:0] SYNC_OUT_MASK = 12'h001,
  parameter logic [GPIO_REG_WIDTH-1:0] TX_OUT_MASK   = 12'h010,
  parameter logic [GPIO_REG_WIDTH-1:0] TRIG_IN_MASK  = 12'h040
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        mode,
  input  logic [NCHAN-1:0]            chan_en,
  input  logic                        gen_ready,
  input  logic [NCHAN*DATA_WIDTH-1:0] gen_i,
  input  logic [NCHAN*DATA_WIDTH-1:0] gen_q,
  output logic                        gen_srst,
  output logic [NCHAN*DATA_WIDTH-1:0] itx,
  output logic [NCHAN*DATA_WIDTH-1:0] qtx,
  output logic                        tx_valid,
  input  logic [GPIO_REG_WIDTH-1:0]   gpio_in,
  output logic [GPIO_REG_WIDTH-1:0]   gpio_out,
  output logic                        busy,
  output logic [2:0]                  state,
  output logic [15:0]                 frame_cnt
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StArm  = 3'd1,
    StS0   = 3'd2,
    StS1   = 3'd3,
    StS2   = 3'd4,
    StRun  = 3'd5
  } state_e;

  localparam logic [CNT_WIDTH-1:0] SyncLast = CNT_WIDTH'(SYNC_LEN);
  localparam logic [CNT_WIDTH-1:0] PayLast  = CNT_WIDTH'(PAYLOAD_LEN);

  state_e                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [15:0]                 frame_q, frame_d;
  logic                        srst_q, srst_d;
  logic                        valid_q, valid_d;
  logic                        busy_q, busy_d;
  logic [GPIO_REG_WIDTH-1:0]   gpio_q, gpio_d;
  logic [NCHAN*DATA_WIDTH-1:0] itx_q, itx_d, qtx_q, qtx_d;
  logic                        pass;
  logic                        trig_ok;

`ifdef MTX_SEQ_EXT_TRIG_EN
  logic       trig_raw;
  logic [2:0] trig_sync_q;
  logic       trig_edge;
  logic       trig_seen_q, trig_seen_d;

  assign trig_raw  = |(gpio_in & TRIG_IN_MASK);
  // Stages 0/1 synchronise; stage 2 is the previous synchronised value for edge detection.
  assign trig_edge = trig_sync_q[1] & ~trig_sync_q[2];
  assign trig_ok   = trig_edge | trig_seen_q;

  always_comb begin
    trig_seen_d = 1'b0;
    if (state_q == StArm && state_d == StArm) begin
      trig_seen_d = trig_seen_q | trig_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_sync_q <= '0;
      trig_seen_q <= 1'b0;
    end else begin
      trig_sync_q <= {trig_sync_q[1:0], trig_raw};
      trig_seen_q <= trig_seen_d;
    end
  end
`else
  logic unused_gpio;
  assign unused_gpio = ^(gpio_in & TRIG_IN_MASK);
  assign trig_ok     = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: state_d = StArm;
        StArm:  if (gen_ready && trig_ok) state_d = StS0;
        StS0:   if (cnt_q == SyncLast) state_d = StS1;
        StS1:   if (cnt_q == SyncLast) state_d = StS2;
        StS2:   if (cnt_q == SyncLast) state_d = StRun;
        StRun: begin
          if (PAYLOAD_LEN != 0 && cnt_q == PayLast) state_d = mode ? StArm : StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    frame_d = frame_q;
    // Counter only runs where it gates a transition, so it can never wrap.
    if (state_q inside {StS0, StS1, StS2} || (state_q == StRun && PAYLOAD_LEN != 0)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_d != state_q) begin
      cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    if (state_q == StRun && state_d != StRun) begin
      frame_d = frame_q + 16'd1;
    end
  end

  // Outputs are decoded from the next state so they change with the state register.
  always_comb begin
    srst_d  = 1'b1;
    valid_d = 1'b0;
    gpio_d  = '0;
    pass    = 1'b0;
    busy_d  = (state_d != StIdle);
    case (state_d)
      StS0: begin
        valid_d = 1'b1;
        pass    = 1'b1;
        gpio_d  = TX_OUT_MASK;
      end
      StS1: begin
        valid_d = 1'b1;
        pass    = 1'b1;
        gpio_d  = SYNC_OUT_MASK | TX_OUT_MASK;
      end
      StS2: gpio_d = SYNC_OUT_MASK;
      StRun: begin
        srst_d  = 1'b0;
        valid_d = 1'b1;
        pass    = 1'b1;
        gpio_d  = TX_OUT_MASK;
      end
      default: ;
    endcase
  end

  always_comb begin
    itx_d = '0;
    qtx_d = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (pass && chan_en[k]) begin
        itx_d[k*DATA_WIDTH +: DATA_WIDTH] = gen_i[k*DATA_WIDTH +: DATA_WIDTH];
        qtx_d[k*DATA_WIDTH +: DATA_WIDTH] = gen_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      frame_q <= '0;
      srst_q  <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      gpio_q  <= '0;
      itx_q   <= '0;
      qtx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      srst_q  <= srst_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      gpio_q  <= gpio_d;
      itx_q   <= itx_d;
      qtx_q   <= qtx_d;
    end
  end

  assign state     = state_q;
  assign gen_srst  = srst_q;
  assign tx_valid  = valid_q;
  assign busy      = busy_q;
  assign gpio_out  = gpio_q;
  assign itx       = itx_q;
  assign qtx       = qtx_q;
  assign frame_cnt = frame_q;

endmodule
